// File: rtl/c_mat_mult_iter_pkg.sv
// Shared constants for the iterative matrix multiplier:
// semiring operator codes, FSM states and the 2-input operator.
package c_mat_mult_iter_pkg;

  localparam int BINARY_OP_AND  = 0;
  localparam int BINARY_OP_OR   = 1;
  localparam int BINARY_OP_XOR  = 2;
  localparam int BINARY_OP_NAND = 3;
  localparam int BINARY_OP_NOR  = 4;
  localparam int BINARY_OP_XNOR = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic c_binary_op(
    input int   op,
    input logic a,
    input logic b
  );
    logic y;
    case (op)
      BINARY_OP_AND:  y = a & b;
      BINARY_OP_OR:   y = a | b;
      BINARY_OP_NAND: y = ~(a & b);
      BINARY_OP_NOR:  y = ~(a | b);
      BINARY_OP_XNOR: y = ~(a ^ b);
      default:        y = a ^ b;
    endcase
    return y;
  endfunction

  function automatic int c_num_passes(input int d1, input int rpc);
    return (d1 + rpc - 1) / rpc;
  endfunction

endpackage

// File: rtl/c_mat_mult_iter_slice.sv
// Combinational product of a rows_per_cycle-row slice of A with B.
// Each output element is an N-port reduction of 2-port products.
module c_mat_mult_slice
  import c_mat_mult_iter_pkg::*;
#(
  parameter int dim2_width     = 1,
  parameter int dim3_width     = 1,
  parameter int rows_per_cycle = 1,
  parameter int prod_op        = BINARY_OP_AND,
  parameter int sum_op         = BINARY_OP_XOR
) (
  input  logic [0:rows_per_cycle*dim2_width-1] a_slice_i,
  input  logic [0:dim2_width*dim3_width-1]     b_i,
  output logic [0:rows_per_cycle*dim3_width-1] y_o
);

  for (genvar gi = 0; gi < rows_per_cycle; gi++) begin : g_row
    for (genvar gc = 0; gc < dim3_width; gc++) begin : g_col
      localparam int YI = gi*dim3_width + gc;
      logic [dim2_width-1:0] prod;

      for (genvar gk = 0; gk < dim2_width; gk++) begin : g_k
        assign prod[gk] = c_binary_op(prod_op,
                                      a_slice_i[gi*dim2_width+gk],
                                      b_i[gk*dim3_width+gc]);
      end

      if (sum_op == BINARY_OP_AND) begin : g_and
        assign y_o[YI] = &prod;
      end else if (sum_op == BINARY_OP_OR) begin : g_or
        assign y_o[YI] = |prod;
      end else if (sum_op == BINARY_OP_NAND) begin : g_nand
        assign y_o[YI] = ~&prod;
      end else if (sum_op == BINARY_OP_NOR) begin : g_nor
        assign y_o[YI] = ~|prod;
      end else if (sum_op == BINARY_OP_XNOR) begin : g_xnor
        assign y_o[YI] = ~^prod;
      end else begin : g_xor
        assign y_o[YI] = ^prod;
      end
    end
  end

endmodule

// File: rtl/c_mat_mult_iter.sv
// Iterative handshaked matrix product: one slice of result rows
// per clock, optional accumulate onto the held result.
module c_mat_mult_iter
  import c_mat_mult_iter_pkg::*;
#(
  parameter int dim1_width     = 1,
  parameter int dim2_width     = 1,
  parameter int dim3_width     = 1,
  parameter int rows_per_cycle = 1,
  parameter int prod_op        = BINARY_OP_AND,
  parameter int sum_op         = BINARY_OP_XOR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             ready_out,
  input  logic [0:dim1_width*dim2_width-1] input_a,
  input  logic [0:dim2_width*dim3_width-1] input_b,
  input  logic                             acc_en,
  output logic                             busy,
  output logic [0:dim1_width*dim3_width-1] result,
  output logic                             result_valid,
  input  logic                             result_ready
);

  localparam int NP = c_num_passes(dim1_width, rows_per_cycle);
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;
  localparam int AW = dim1_width*dim2_width;
  localparam int BW = dim2_width*dim3_width;
  localparam int RW = dim1_width*dim3_width;
  localparam int SA = rows_per_cycle*dim2_width;
  localparam int SY = rows_per_cycle*dim3_width;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [0:AW-1] a_q;
  logic [0:BW-1] b_q;
  logic          acc_q;
  logic [0:RW-1] res_q;
  logic [0:RW-1] res_d;
  logic          busy_q;
  logic          valid_q;

  logic          accept;
  logic          last_pass;
  logic [NP-1:0] pass_sel;
  logic [0:SA-1] a_slice;
  logic [0:SY-1] slice_y;

  assign ready_out = (state_q == ST_IDLE) |
                     ((state_q == ST_DONE) & result_ready);
  assign accept    = start & ready_out;
  assign last_pass = (cnt_q == CW'(NP-1));

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = res_q;

  for (genvar gp = 0; gp < NP; gp++) begin : g_sel
    assign pass_sel[gp] = (state_q == ST_BUSY) &
                          (cnt_q == CW'(gp));
  end

  // Lanes that fall past the last row see zeros, never an A index.
  for (genvar gi = 0; gi < rows_per_cycle; gi++) begin : g_lane
    for (genvar gk = 0; gk < dim2_width; gk++) begin : g_k
      logic [NP-1:0] col;
      for (genvar gp = 0; gp < NP; gp++) begin : g_p
        localparam int R = gp*rows_per_cycle + gi;
        if (R < dim1_width) begin : g_in
          assign col[gp] = a_q[R*dim2_width+gk];
        end else begin : g_out
          assign col[gp] = 1'b0;
        end
      end
      assign a_slice[gi*dim2_width+gk] = |(col & pass_sel);
    end
  end

  c_mat_mult_slice #(
    .dim2_width     (dim2_width),
    .dim3_width     (dim3_width),
    .rows_per_cycle (rows_per_cycle),
    .prod_op        (prod_op),
    .sum_op         (sum_op)
  ) u_slice (
    .a_slice_i (a_slice),
    .b_i       (b_q),
    .y_o       (slice_y)
  );

  for (genvar gr = 0; gr < dim1_width; gr++) begin : g_wr
    localparam int GP = gr / rows_per_cycle;
    localparam int GI = gr % rows_per_cycle;
    for (genvar gc = 0; gc < dim3_width; gc++) begin : g_c
      localparam int RI = gr*dim3_width + gc;
      logic nv;
      assign nv = acc_q ?
                  c_binary_op(sum_op, res_q[RI],
                              slice_y[GI*dim3_width+gc]) :
                  slice_y[GI*dim3_width+gc];
      assign res_d[RI] = pass_sel[GP] ? nv : res_q[RI];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q <= res_d;
      if (accept) begin
        a_q   <= input_a;
        b_q   <= input_b;
        acc_q <= acc_en;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BUSY;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (last_pass) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            if (accept) begin
              state_q <= ST_BUSY;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c_mat_mult_iter.sv
// Directed bench for c_mat_mult_iter over GF(2):
// three instances cover P=2, a partial last pass and P=3.
module tb_c_mat_mult_iter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  logic       s0, rr0, acc0, rdy0, bsy0, vld0;
  logic [0:3] a0, b0, res0;
  logic       s1, rr1, acc1, rdy1, bsy1, vld1;
  logic [0:5] a1, res1;
  logic [0:3] b1;
  logic       s2, rr2, acc2, rdy2, bsy2, vld2;
  logic [0:5] a2, res2;
  logic [0:3] b2;

  c_mat_mult_iter #(
    .dim1_width(2), .dim2_width(2), .dim3_width(2), .rows_per_cycle(1)
  ) u0 (
    .clk(clk), .reset(reset), .start(s0), .ready_out(rdy0),
    .input_a(a0), .input_b(b0), .acc_en(acc0), .busy(bsy0),
    .result(res0), .result_valid(vld0), .result_ready(rr0)
  );

  c_mat_mult_iter #(
    .dim1_width(3), .dim2_width(2), .dim3_width(2), .rows_per_cycle(2)
  ) u1 (
    .clk(clk), .reset(reset), .start(s1), .ready_out(rdy1),
    .input_a(a1), .input_b(b1), .acc_en(acc1), .busy(bsy1),
    .result(res1), .result_valid(vld1), .result_ready(rr1)
  );

  c_mat_mult_iter #(
    .dim1_width(3), .dim2_width(2), .dim3_width(2), .rows_per_cycle(1)
  ) u2 (
    .clk(clk), .reset(reset), .start(s2), .ready_out(rdy2),
    .input_a(a2), .input_b(b2), .acc_en(acc2), .busy(bsy2),
    .result(res2), .result_valid(vld2), .result_ready(rr2)
  );

  initial begin
    s0 = 0; rr0 = 0; acc0 = 0; a0 = '0; b0 = '0;
    s1 = 0; rr1 = 0; acc1 = 0; a1 = '0; b1 = '0;
    s2 = 0; rr2 = 0; acc2 = 0; a2 = '0; b2 = '0;

    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_bsy", 32'(bsy0), 32'd0);
    chk("rst_vld", 32'(vld0), 32'd0);
    chk("rst_res", 32'(res0), 32'd0);
    reset = 0;
    @(negedge clk);

    // 2x2x2 plain product
    a0 = 4'b1101; b0 = 4'b1011; acc0 = 0; s0 = 1;
    chk("t1_rdy_idle", 32'(rdy0), 32'd1);
    @(negedge clk);
    s0 = 0; a0 = '0; b0 = '0;
    chk("t1_bsy_e0", 32'(bsy0), 32'd1);
    chk("t1_vld_e0", 32'(vld0), 32'd0);
    @(negedge clk);
    chk("t1_bsy_e1", 32'(bsy0), 32'd1);
    chk("t1_vld_e1", 32'(vld0), 32'd0);
    @(negedge clk);
    chk("t1_vld_e2", 32'(vld0), 32'd1);
    chk("t1_bsy_e2", 32'(bsy0), 32'd0);
    chk("t1_res", 32'(res0), 32'b0111);
    chk("t1_rdy_done", 32'(rdy0), 32'd0);

    // hold in DONE, stray start must be ignored
    for (int i = 0; i < 5; i++) begin
      s0 = (i == 2); a0 = 4'b1111; b0 = 4'b1111;
      @(negedge clk);
      chk("t4_vld", 32'(vld0), 32'd1);
      chk("t4_res", 32'(res0), 32'b0111);
      chk("t4_rdy", 32'(rdy0), 32'd0);
      chk("t4_bsy", 32'(bsy0), 32'd0);
    end
    s0 = 0; rr0 = 1;
    #1 chk("t4_rdy_pass", 32'(rdy0), 32'd1);
    @(negedge clk);
    rr0 = 0;
    chk("t4_vld_ret", 32'(vld0), 32'd0);
    chk("t4_rdy_idle", 32'(rdy0), 32'd1);
    chk("t4_res_kept", 32'(res0), 32'b0111);

    // accumulate the same product onto held result
    a0 = 4'b1101; b0 = 4'b1011; acc0 = 1; s0 = 1;
    @(negedge clk);
    s0 = 0; acc0 = 0;
    repeat (2) @(negedge clk);
    chk("t2_vld", 32'(vld0), 32'd1);
    chk("t2_res", 32'(res0), 32'b0000);

    // retire and start in the same cycle
    rr0 = 1; s0 = 1; a0 = 4'b1000; b0 = 4'b1011; acc0 = 0;
    @(negedge clk);
    rr0 = 0; s0 = 0;
    chk("t5_bsy", 32'(bsy0), 32'd1);
    chk("t5_vld", 32'(vld0), 32'd0);
    @(negedge clk);
    chk("t5_vld_e1", 32'(vld0), 32'd0);
    @(negedge clk);
    chk("t5_vld_e2", 32'(vld0), 32'd1);
    chk("t5_res", 32'(res0), 32'b1000);
    rr0 = 1;
    @(negedge clk);
    rr0 = 0;

    // dim1=3, rpc=2: partial last pass
    a1 = 6'b110111; b1 = 4'b1011; acc1 = 0; s1 = 1;
    @(negedge clk);
    s1 = 0;
    chk("t3_bsy", 32'(bsy1), 32'd1);
    @(negedge clk);
    chk("t3_vld_e1", 32'(vld1), 32'd0);
    chk("t3_res_p0", 32'(res1), 32'b011100);
    @(negedge clk);
    chk("t3_vld", 32'(vld1), 32'd1);
    chk("t3_bsy_e2", 32'(bsy1), 32'd0);
    chk("t3_res", 32'(res1), 32'b011101);
    rr1 = 1;
    @(negedge clk);
    rr1 = 0;
    chk("t3_rdy_idle", 32'(rdy1), 32'd1);

    // reset mid-job on P=3 instance
    a2 = 6'b110111; b2 = 4'b1011; acc2 = 0; s2 = 1;
    @(negedge clk);
    s2 = 0;
    @(negedge clk);
    chk("t6_bsy", 32'(bsy2), 32'd1);
    chk("t6_res_p0", 32'(res2), 32'b010000);
    reset = 1;
    #1;
    chk("t6_rst_bsy", 32'(bsy2), 32'd0);
    chk("t6_rst_vld", 32'(vld2), 32'd0);
    chk("t6_rst_rdy", 32'(rdy2), 32'd1);
    chk("t6_rst_res", 32'(res2), 32'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    a2 = 6'b100001; b2 = 4'b1011; s2 = 1;
    @(negedge clk);
    s2 = 0;
    @(negedge clk);
    chk("t6_vld_e1", 32'(vld2), 32'd0);
    @(negedge clk);
    chk("t6_vld_e2", 32'(vld2), 32'd0);
    @(negedge clk);
    chk("t6_vld_e3", 32'(vld2), 32'd1);
    chk("t6_res", 32'(res2), 32'b100011);
    rr2 = 1;
    @(negedge clk);
    rr2 = 0;
    chk("t6_rdy_idle", 32'(rdy2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
